// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view. The master modport is the view of
// the producers and transmitter (or a bench standing in for them).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 err_timeout;

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_done,
    output req_ready,
    output tx_data,
    output tx_start,
    output grant_id,
    output busy,
    output err_timeout
  );

  modport master (
    output req_valid,
    output req_data,
    output tx_done,
    input  req_ready,
    input  tx_data,
    input  tx_start,
    input  grant_id,
    input  busy,
    input  err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Each grant accepts one byte and fires a one-cycle tx_start. The arbiter then
// waits for tx_done, or for a watchdog of TIMEOUT cycles, before it arbitrates again.
// Optional feature macro: UART_ARB_BURST_EN. When it is defined, the current owner
// keeps priority for up to BURST_LEN consecutive bytes while it keeps asserting valid.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 4096,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            err_timeout_q, err_timeout_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

`ifdef UART_ARB_BURST_EN
  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] ready_vec;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      cand;
  logic [ID_W-1:0]    next_ptr;

  // Split the flat data bus into bytes, and build the one-hot ready for the winner.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_byte[gi]  = bus.req_data[8*gi +: 8];
      assign ready_vec[gi] = (state_q == S_IDLE) && win_found && (win_idx == ID_W'(gi));
    end
  endgenerate

  // Ready is forced low while reset is held, even before the flops settle.
  assign bus.req_ready = rst ? '0 : ready_vec;

  // Scan the requesters starting at rr_ptr and wrapping; the first valid one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (!win_found && bus.req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Pointer value that hands priority to the requester after the last owner.
  always_comb begin
    next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
  end

  // Compute the next state and the next values of all registered outputs.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = 1'b0;
`ifdef UART_ARB_BURST_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // When a winner exists its ready is high and its valid is high, so a transfer happens.
        if (win_found) begin
          tx_data_d  = req_byte[win_idx];
          grant_id_d = win_idx;
          state_d    = S_START;
        end
      end
      S_START: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        // If tx_done and watchdog expiry arrive together, tx_done wins and no error is raised.
        if (bus.tx_done) begin
          state_d = S_IDLE;
`ifdef UART_ARB_BURST_EN
          if (bus.req_valid[grant_id_q] && (burst_cnt_q < BURST_LAST)) begin
            rr_ptr_d    = grant_id_q;
            burst_cnt_d = burst_cnt_q + BC_W'(1);
          end else begin
            rr_ptr_d    = next_ptr;
            burst_cnt_d = '0;
          end
`else
          rr_ptr_d = next_ptr;
`endif
        end else if (wd_cnt_q == WD_LAST) begin
          state_d       = S_IDLE;
          err_timeout_d = 1'b1;
          rr_ptr_d      = next_ptr;
`ifdef UART_ARB_BURST_EN
          burst_cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // tx_start is a registered copy of "in START", so it lasts exactly one cycle.
    tx_start_d = (state_d == S_START);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_cnt_q      <= '0;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      err_timeout_q <= err_timeout_d;
      wd_cnt_q      <= wd_cnt_d;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q   <= burst_cnt_d;
`endif
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Each test pushes the expected grants as {id, byte}. A negedge monitor pops
// and compares one entry on every tx_start pulse.
// Build with or without UART_ARB_BURST_EN; only the burst test's expected order changes.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT   = 24;
  localparam int BURST_LEN = 4;
  localparam int MAX_WAIT  = 200;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .TIMEOUT  (TIMEOUT),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cnt = 0;
  exp_t exp_q[$];

  // Scoreboard monitor: every tx_start must match the oldest expected grant.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.tx_start === 1'b1) begin
      start_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_start: got id=%0d data=%h, required no grant", bus.grant_id, bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.grant_id !== e.id || bus.tx_data !== e.data) begin
          n_err++;
          $display("FAIL sb_grant: got id=%0d data=%h, required id=%0d data=%h",
                   bus.grant_id, bus.tx_data, e.id, e.data);
        end else begin
          $display("grant id=%0d data=%h at %0t", bus.grant_id, bus.tx_data, $time);
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id[1:0];
    e.data = data;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.tx_done   = 1'b0;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a tx_start pulse and returns how many negedges it took.
  task automatic wait_start(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      #1;
      if (bus.tx_start === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_start: no tx_start within %0d cycles, required a pulse", MAX_WAIT);
    end
  endtask

  task automatic pulse_done_after(input int n);
    repeat (n) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int cyc;
    int sc;
    // Reset state, with all requesters valid while reset is held.
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.tx_done   = 1'b0;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    #12;
    n_cmp++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0 || bus.tx_start !== 1'b0 ||
        bus.grant_id !== 2'd0 || bus.err_timeout !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b busy=%b start=%b id=%0d err=%b data=%h, required all zero",
               bus.req_ready, bus.busy, bus.tx_start, bus.grant_id, bus.err_timeout, bus.tx_data);
    end
    do_reset();
    // Reset applied mid-WAIT after a grant to requester 3.
    @(negedge clk);
    bus.req_valid = 4'b1000;
    exp_q.push_back(mk(3, 8'h13));
    wait_start(ok, cyc);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got busy=%b start=%b ready=%b id=%0d, required 0 0 0000 0",
               bus.busy, bus.tx_start, bus.req_ready, bus.grant_id);
    end
    // Reset applied during the START cycle kills the tx_start pulse at once.
    exp_q.push_back(mk(3, 8'h13));
    @(negedge clk);
    rst = 1'b0;
    wait_start(ok, cyc);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_start: got start=%b busy=%b id=%0d, required 0 0 0",
               bus.tx_start, bus.busy, bus.grant_id);
    end
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
    // The abandoned byte must not be re-sent.
    sc = start_cnt;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (start_cnt != sc || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_abandon: got %0d extra starts, %0d pending, required 0 0", start_cnt - sc, exp_q.size());
    end
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    int sc;
    do_reset();
    sc = start_cnt;
    @(negedge clk);
    bus.req_data[23:16] = 8'hA5;
    bus.req_valid = 4'b0100;
    exp_q.push_back(mk(2, 8'hA5));
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b, required 0100", bus.req_ready);
    end
    wait_start(ok, cyc);
    n_cmp++;
    if (cyc != 1) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles, required 1", cyc);
    end
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL single_wait: got start=%b busy=%b ready=%b, required 0 1 0000",
               bus.tx_start, bus.busy, bus.req_ready);
    end
    pulse_done_after(19);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got busy=%b err=%b, required 0 0", bus.busy, bus.err_timeout);
    end
    // rr_ptr should now be 3, so requester 3 wins with all valid.
    bus.req_valid = 4'hF;
    exp_q.push_back(mk(3, 8'h13));
    wait_start(ok, cyc);
    bus.req_valid = '0;
    pulse_done_after(5);
    @(negedge clk);
    n_cmp++;
    if (start_cnt - sc != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_count: got %0d starts, %0d pending, required 2 0", start_cnt - sc, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int cyc;
    int sc;
    do_reset();
    sc = start_cnt;
    @(negedge clk);
    bus.req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      exp_q.push_back(mk(j % 4, 8'h10 + 8'(j % 4)));
    end
    for (int j = 0; j < 5; j++) begin
      wait_start(ok, cyc);
      if (j == 4) bus.req_valid = '0;
      pulse_done_after(10);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (start_cnt - sc != 5 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rr_count: got %0d starts, %0d pending, busy=%b, required 5 0 0",
               start_cnt - sc, exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    int c;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'hF;
    exp_q.push_back(mk(0, 8'h10));
    exp_q.push_back(mk(1, 8'h11));
    wait_start(ok, cyc);
    c = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      #1;
      if (bus.err_timeout === 1'b1) begin
        c = i;
        break;
      end
    end
    n_cmp++;
    if (c != TIMEOUT + 1) begin
      n_err++;
      $display("FAIL timeout_delay: got err after %0d cycles, required %0d", c, TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy);
    end
    wait_start(ok, cyc);
    n_cmp++;
    if (cyc != 1 || bus.err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_regrant: got %0d cycles err=%b, required 1 0", cyc, bus.err_timeout);
    end
    bus.req_valid = '0;
    pulse_done_after(5);
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.err_timeout !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_end: got err=%b pending=%0d, required 0 0", bus.err_timeout, exp_q.size());
    end
  endtask

  task automatic test_burst();
    bit ok;
    int cyc;
    int n;
`ifdef UART_ARB_BURST_EN
    int order[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    n = 9;
`else
    int order[4] = '{0, 1, 0, 1};
    n = 4;
`endif
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0011;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(mk(order[j], 8'h10 + 8'(order[j])));
    end
    for (int j = 0; j < n; j++) begin
      wait_start(ok, cyc);
      if (j == n - 1) bus.req_valid = '0;
      pulse_done_after(4);
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL burst_order: got %0d grants pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stray_done();
    bit ok;
    int cyc;
    do_reset();
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b0 || bus.grant_id !== 2'd0 || bus.tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL stray_done: got busy=%b err=%b id=%0d start=%b, required 0 0 0 0",
               bus.busy, bus.err_timeout, bus.grant_id, bus.tx_start);
    end
    bus.req_valid = 4'hF;
    exp_q.push_back(mk(0, 8'h10));
    wait_start(ok, cyc);
    bus.req_valid = '0;
    pulse_done_after(3);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stray_next: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_burst();
    test_stray_done();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
